histogram_engine: RTL and testbench

- Responder to the equalization top-level controller for the histogram phase.
- On histogram_start_pulse it clears all 2^PIXEL_W bins in scratch memory, then streams NUM_PIXELS pixels from input memory, doing one read-modify-write increment per pixel.
- Reports input_mem_done once the last pixel has been fetched and pulses histogram_computation_done when the last bin write has been issued.
- Sits between the controller, the input image memory and the scratch (histogram) memory.

---
 rtl/histogram_engine.sv | 145 ++++++++++++++
 tb/tb_histogram_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_engine.sv
// Histogram phase engine: clears every bin in scratch memory, then does one
// read-modify-write increment per input pixel with saturating bin counters.
module histogram_engine #(
    parameter int PIXEL_W    = 8,
    parameter int BIN_W      = 16,
    parameter int NUM_PIXELS = 1024,
    parameter int IN_ADDR_W  = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 histogram_start_pulse,
    input  logic                 histogram_en,
    output logic                 in_mem_rd_en,
    output logic [IN_ADDR_W-1:0] in_mem_addr,
    input  logic [PIXEL_W-1:0]   in_mem_rdata,
    output logic                 hist_rd_en,
    output logic                 hist_wr_en,
    output logic [PIXEL_W-1:0]   hist_addr,
    output logic [BIN_W-1:0]     hist_wdata,
    input  logic [BIN_W-1:0]     hist_rdata,
    output logic                 input_mem_done,
    output logic                 histogram_computation_done,
    output logic                 busy,
    output logic                 bin_saturate_fault
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        PIX_WAIT,
        BIN_RD,
        BIN_WR,
        DONE
    } state_t;

    localparam logic [IN_ADDR_W-1:0] LAST_PIX = IN_ADDR_W'(NUM_PIXELS - 1);

    state_t               state_q, state_d;
    logic [PIXEL_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IN_ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIXEL_W-1:0]   pix_q, pix_d;
    logic                 imd_q, imd_d;
    logic                 fault_q, fault_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            pix_cnt_q <= '0;
            pix_q     <= '0;
            imd_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            pix_q     <= pix_d;
            imd_q     <= imd_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        pix_d        = pix_q;
        imd_d        = imd_q;
        fault_d      = fault_q;
        in_mem_rd_en = 1'b0;
        in_mem_addr  = '0;
        hist_rd_en   = 1'b0;
        hist_wr_en   = 1'b0;
        hist_addr    = '0;
        hist_wdata   = '0;
        histogram_computation_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (histogram_start_pulse) begin
                    clr_cnt_d = '0;
                    pix_cnt_d = '0;
                    imd_d     = 1'b0;
                    fault_d   = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (histogram_en) begin
                    hist_wr_en = 1'b1;
                    hist_addr  = clr_cnt_q;
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) state_d = FETCH;
                end
            end
            FETCH: begin
                if (histogram_en) begin
                    in_mem_rd_en = 1'b1;
                    in_mem_addr  = pix_cnt_q;
                    state_d      = PIX_WAIT;
                end
            end
            PIX_WAIT: begin
                pix_d = in_mem_rdata;
                if (pix_cnt_q == LAST_PIX) imd_d = 1'b1;
                state_d = BIN_RD;
            end
            BIN_RD: begin
                if (histogram_en) begin
                    hist_rd_en = 1'b1;
                    hist_addr  = pix_q;
                    state_d    = BIN_WR;
                end
            end
            BIN_WR: begin
                // Not stallable: the bin read issued last cycle is only valid now.
                hist_wr_en = 1'b1;
                hist_addr  = pix_q;
                if (hist_rdata == '1) begin
                    hist_wdata = '1;
                    fault_d    = 1'b1;
                end else begin
                    hist_wdata = hist_rdata + BIN_W'(1);
                end
                if (pix_cnt_q == LAST_PIX) begin
                    state_d = DONE;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    state_d   = FETCH;
                end
            end
            DONE: begin
                histogram_computation_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign input_mem_done     = imd_q;
    assign bin_saturate_fault = fault_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_histogram_engine.sv
// Self-checking bench for histogram_engine: behavioural input/scratch memories
// plus a reference histogram computed by counting pixels directly.
module tb_histogram_engine;

    localparam int PW   = 8;
    localparam int BW   = 2;
    localparam int NP   = 4;
    localparam int AW   = 2;
    localparam int NB   = 1 << PW;
    localparam int BMAX = (1 << BW) - 1;

    logic          clock;
    logic          reset;
    logic          start;
    logic          en;
    logic          in_rd;
    logic [AW-1:0] in_addr;
    logic [PW-1:0] in_rdata;
    logic          h_rd;
    logic          h_wr;
    logic [PW-1:0] h_addr;
    logic [BW-1:0] h_wdata;
    logic [BW-1:0] h_rdata;
    logic          imd;
    logic          done;
    logic          busy;
    logic          fault;

    int checks;
    int errors;

    logic [PW-1:0] in_mem [NP];
    logic [BW-1:0] scr [NB];
    logic          prefill_req;

    histogram_engine #(
        .PIXEL_W   (PW),
        .BIN_W     (BW),
        .NUM_PIXELS(NP),
        .IN_ADDR_W (AW)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .histogram_start_pulse     (start),
        .histogram_en              (en),
        .in_mem_rd_en              (in_rd),
        .in_mem_addr               (in_addr),
        .in_mem_rdata              (in_rdata),
        .hist_rd_en                (h_rd),
        .hist_wr_en                (h_wr),
        .hist_addr                 (h_addr),
        .hist_wdata                (h_wdata),
        .hist_rdata                (h_rdata),
        .input_mem_done            (imd),
        .histogram_computation_done(done),
        .busy                      (busy),
        .bin_saturate_fault        (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memories; prefill scribbles garbage so the clear is observable.
    always @(posedge clock) begin
        if (in_rd) in_rdata <= in_mem[in_addr];
        if (prefill_req) begin
            for (int i = 0; i < NB; i++) scr[i] <= BW'($urandom);
        end else if (h_wr) begin
            scr[h_addr] <= h_wdata;
        end
        if (h_rd) h_rdata <= scr[h_addr];
    end

    task automatic load_random(input int lim);
        for (int p = 0; p < NP; p++) in_mem[p] = PW'($urandom_range(0, lim));
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_image(input string nm, input bit prefill, input int clr_a, input int clr_len,
                             input int bin_k, input int bin_len, input int extra_t, input bit linger);
        int ref_cnt [NB];
        bit exp_fault;
        int exp_done, exp_imd, bin_a;
        int t, t_done, t_imd, wr_cnt, rd_cnt, in_cnt, viol, bad_bins;
        logic fault_at_done;
        logic [BW-1:0] exp_bin;

        for (int b = 0; b < NB; b++) ref_cnt[b] = 0;
        for (int p = 0; p < NP; p++) ref_cnt[in_mem[p]]++;
        exp_fault = 1'b0;
        for (int b = 0; b < NB; b++) if (ref_cnt[b] > BMAX) exp_fault = 1'b1;
        exp_done = NB + 4 * NP + clr_len + bin_len;
        exp_imd  = NB + 4 * NP - 2 + clr_len + ((bin_k < NP - 1) ? bin_len : 0);
        bin_a    = NB + 2 + 4 * bin_k + clr_len;

        if (prefill) begin
            prefill_req = 1'b1;
            @(posedge clock); #1;
            prefill_req = 1'b0;
        end
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;

        t = 0; t_done = -1; t_imd = -1;
        wr_cnt = 0; rd_cnt = 0; in_cnt = 0; viol = 0;
        fault_at_done = 1'b0;
        while (t_done < 0 && t < 2000) begin
            en    = !((t >= clr_a && t < clr_a + clr_len) || (t >= bin_a && t < bin_a + bin_len));
            start = (t == extra_t);
            @(negedge clock);
            if (t == 0) begin
                checks++;
                if (busy !== 1'b1 || imd !== 1'b0 || fault !== 1'b0) begin
                    errors++;
                    $display("FAIL %s start_state busy=%b imd=%b fault=%b want 1 0 0", nm, busy, imd, fault);
                end
            end
            if (!en && (in_rd || h_rd || h_wr)) viol++;
            if (h_wr) wr_cnt++;
            if (h_rd) rd_cnt++;
            if (in_rd) in_cnt++;
            if (imd && t_imd < 0) t_imd = t;
            if (done) begin
                t_done = t;
                fault_at_done = fault;
            end
            @(posedge clock); #1;
            t++;
        end
        start = 1'b0;
        en    = 1'b1;

        checks++;
        if (t_done != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", nm, t_done, exp_done);
        end
        checks++;
        if (t_imd != exp_imd) begin
            errors++;
            $display("FAIL %s input_mem_done_cycle got %0d want %0d", nm, t_imd, exp_imd);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL %s strobes_during_stall got %0d want 0", nm, viol);
        end
        checks++;
        if (wr_cnt != NB + NP || rd_cnt != NP || in_cnt != NP) begin
            errors++;
            $display("FAIL %s strobe_counts wr=%0d rd=%0d in=%0d want %0d %0d %0d",
                     nm, wr_cnt, rd_cnt, in_cnt, NB + NP, NP, NP);
        end
        checks++;
        if (fault_at_done !== exp_fault) begin
            errors++;
            $display("FAIL %s fault_at_done got %b want %b", nm, fault_at_done, exp_fault);
        end
        bad_bins = 0;
        for (int b = 0; b < NB; b++) begin
            exp_bin = (ref_cnt[b] > BMAX) ? BW'(BMAX) : BW'(ref_cnt[b]);
            if (scr[b] !== exp_bin) begin
                if (bad_bins < 4) $display("  %s bin %0d got %0d want %0d", nm, b, scr[b], exp_bin);
                bad_bins++;
            end
        end
        checks++;
        if (bad_bins != 0) begin
            errors++;
            $display("FAIL %s histogram got %0d wrong bins want 0", nm, bad_bins);
        end

        if (linger) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || imd !== 1'b1 || fault !== exp_fault) begin
                errors++;
                $display("FAIL %s after_done done=%b busy=%b imd=%b fault=%b want 0 0 1 %b",
                         nm, done, busy, imd, fault, exp_fault);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; en = 1'b1; prefill_req = 1'b0;
        for (int p = 0; p < NP; p++) in_mem[p] = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, imd, fault, in_rd, h_rd, h_wr} !== 7'b0 || in_addr !== '0 || h_addr !== '0 || h_wdata !== '0) begin
            errors++;
            $display("FAIL reset_idle outputs busy=%b done=%b imd=%b fault=%b wr=%b want all 0", busy, done, imd, fault, h_wr);
        end
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, imd, fault, in_rd, h_rd, h_wr} !== 7'b0 || h_addr !== '0) begin
            errors++;
            $display("FAIL reset_async outputs busy=%b wr=%b addr=%0d want 0 0 0", busy, h_wr, h_addr);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        in_mem[0] = 8'd5; in_mem[1] = 8'd5; in_mem[2] = 8'd5; in_mem[3] = 8'd200;
        run_image("basic", 1'b1, -100, 0, 0, 0, -1, 1'b1);
    endtask

    task automatic test_stall();
        in_mem[0] = 8'd5; in_mem[1] = 8'd5; in_mem[2] = 8'd5; in_mem[3] = 8'd200;
        run_image("stall", 1'b1, $urandom_range(0, 240), 10, $urandom_range(0, NP - 1), 3, -1, 1'b1);
    endtask

    task automatic test_saturation();
        for (int p = 0; p < NP; p++) in_mem[p] = 8'd7;
        run_image("saturate", 1'b1, -100, 0, 0, 0, -1, 1'b1);
    endtask

    task automatic test_start_while_busy();
        load_random(255);
        run_image("busy_start_clear", 1'b1, -100, 0, 0, 0, $urandom_range(1, 250), 1'b1);
        load_random(3);
        run_image("busy_start_pixels", 1'b1, -100, 0, 0, 0, NB + $urandom_range(0, 4 * NP - 1), 1'b1);
    endtask

    task automatic test_reset_mid_bin();
        load_random(255);
        prefill_req = 1'b1;
        @(posedge clock); #1;
        prefill_req = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (NB + 6) @(posedge clock);
        #1;
        checks++;
        if (h_rd !== 1'b1 || h_addr !== in_mem[1]) begin
            errors++;
            $display("FAIL rst_bin_rd_reached rd=%b addr=%0d want 1 %0d", h_rd, h_addr, in_mem[1]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (h_wr !== 1'b0 || h_rd !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_bin_rd outputs wr=%b rd=%b busy=%b want 0 0 0", h_wr, h_rd, busy);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        load_random(3);
        run_image("after_reset", 1'b1, -100, 0, 0, 0, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] v;
        v = PW'($urandom_range(0, 255));
        for (int p = 0; p < NP; p++) in_mem[p] = v;
        run_image("b2b_first", 1'b1, -100, 0, 0, 0, -1, 1'b0);
        load_random(255);
        in_mem[0] = v + 8'd1;
        run_image("b2b_second", 1'b0, -100, 0, 0, 0, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            load_random((i % 2 == 0) ? 3 : 255);
            run_image("random", 1'b1, $urandom_range(0, 255), $urandom_range(0, 6),
                      $urandom_range(0, NP - 1), $urandom_range(0, 4), -1, 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_start_while_busy();
        test_reset_mid_bin();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
